// File: rtl/cpu_pkg.sv
// Shared CPU datapath definitions: default register-file geometry and
// the register reset-value rule.
package cpu_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 3;

    // Register i resets to i+1; callers truncate to the register width,
    // which supplies the modulo 2**DATA_W wrap.
    function automatic int unsigned rf_rst_val(input int unsigned i);
        return i + 1;
    endfunction

endpackage

// File: rtl/rf_read_port.sv
// One register-file read port: address mux, write bypass, optional output
// register and pending-write (busy) lookup.
module rf_read_port
    import cpu_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int REG_RD = 0,
    parameter int BYPASS = 1
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic [ADDR_W-1:0]                       raddr,
    input  logic [(1<<ADDR_W)-1:0][DATA_W-1:0]      regs,
    input  logic [(1<<ADDR_W)-1:0]                  busy,
    input  logic                                    wr_en,
    input  logic [ADDR_W-1:0]                       waddr,
    input  logic [DATA_W-1:0]                       wdata,
    input  logic                                    set_en,
    input  logic [ADDR_W-1:0]                       busy_addr,
    output logic [DATA_W-1:0]                       rdata,
    output logic                                    rd_busy
);

    logic              hit;
    logic [DATA_W-1:0] data_d;
    logic              busy_d;
    logic [DATA_W-1:0] rdata_q;
    logic              rd_busy_q;

    // wr_en/set_en arrive already qualified by clr and the zero register.
    assign hit    = (BYPASS != 0) && wr_en && (waddr == raddr);
    assign data_d = hit ? wdata : regs[raddr];
    assign busy_d = hit ? (set_en && (busy_addr == raddr)) : busy[raddr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q   <= '0;
            rd_busy_q <= 1'b0;
        end else begin
            rdata_q   <= data_d;
            rd_busy_q <= busy_d;
        end
    end

    assign rdata   = (REG_RD != 0) ? rdata_q   : data_d;
    assign rd_busy = (REG_RD != 0) ? rd_busy_q : busy_d;

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file with write bypass, optional hardwired zero
// register and a per-register pending-write scoreboard.
module regfile_mp
    import cpu_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int N_RD     = 2,
    parameter int ZERO_REG = 0,
    parameter int REG_RD   = 0,
    parameter int BYPASS   = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     we,
    input  logic [ADDR_W-1:0]        waddr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic [N_RD*ADDR_W-1:0]   raddr,
    output logic [N_RD*DATA_W-1:0]   rdata,
    input  logic                     busy_set,
    input  logic [ADDR_W-1:0]        busy_addr,
    output logic [N_RD-1:0]          rd_busy
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DEPTH-1:0][DATA_W-1:0] regs;
    logic [DEPTH-1:0]             busy;
    logic                         wr_en;
    logic                         set_en;

    // clr outranks both the write and the busy mark; reg 0 may be hardwired.
    assign wr_en  = we && !clr && !((ZERO_REG != 0) && (waddr == '0));
    assign set_en = busy_set && !clr && !((ZERO_REG != 0) && (busy_addr == '0));

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_reg
            localparam logic [DATA_W-1:0] RST_VAL =
                ((ZERO_REG != 0) && (gi == 0)) ? '0 : DATA_W'(rf_rst_val(gi));

            logic [DATA_W-1:0] reg_q;
            logic              busy_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    reg_q <= RST_VAL;
                end else if (clr) begin
                    reg_q <= RST_VAL;
                end else if (wr_en && (waddr == ADDR_W'(gi))) begin
                    reg_q <= wdata;
                end
            end

            // A new producer marked in the same cycle as a writeback stays pending.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    busy_q <= 1'b0;
                end else if (clr) begin
                    busy_q <= 1'b0;
                end else if (set_en && (busy_addr == ADDR_W'(gi))) begin
                    busy_q <= 1'b1;
                end else if (wr_en && (waddr == ADDR_W'(gi))) begin
                    busy_q <= 1'b0;
                end
            end

            assign regs[gi] = reg_q;
            assign busy[gi] = busy_q;
        end

        for (genvar gi = 0; gi < N_RD; gi++) begin : g_rd
            rf_read_port #(
                .DATA_W (DATA_W),
                .ADDR_W (ADDR_W),
                .REG_RD (REG_RD),
                .BYPASS (BYPASS)
            ) u_port (
                .clk       (clk),
                .rst_n     (rst_n),
                .raddr     (raddr[gi*ADDR_W +: ADDR_W]),
                .regs      (regs),
                .busy      (busy),
                .wr_en     (wr_en),
                .waddr     (waddr),
                .wdata     (wdata),
                .set_en    (set_en),
                .busy_addr (busy_addr),
                .rdata     (rdata[gi*DATA_W +: DATA_W]),
                .rd_busy   (rd_busy[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_regfile_mp.sv
// Checks two register-file configurations side by side: the default
// (combinational read, bypass) and a zero-register/registered-read/no-bypass one.
module tb_regfile_mp;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clr = 1'b0;
    logic        we = 1'b0;
    logic [2:0]  waddr = '0;
    logic [7:0]  wdata = '0;
    logic        busy_set = 1'b0;
    logic [2:0]  busy_addr = '0;
    logic [2:0]  ra [2];
    logic [5:0]  raddr;
    logic [15:0] rdata_a, rdata_b;
    logic [1:0]  rd_busy_a, rd_busy_b;

    int n_cmp = 0;
    int n_err = 0;

    // Reference state: plain arrays updated by the architectural rules.
    logic [7:0] mem_a [8];
    logic       bsy_a [8];
    logic [7:0] mem_b [8];
    logic       bsy_b [8];
    logic [7:0] pend_d [2];
    logic       pend_b [2];

    always #5 clk = ~clk;
    assign raddr = {ra[1], ra[0]};

    regfile_mp #(.ZERO_REG(0), .REG_RD(0), .BYPASS(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .clr(clr), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr(raddr), .rdata(rdata_a), .busy_set(busy_set), .busy_addr(busy_addr),
        .rd_busy(rd_busy_a));

    regfile_mp #(.ZERO_REG(1), .REG_RD(1), .BYPASS(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .clr(clr), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr(raddr), .rdata(rdata_b), .busy_set(busy_set), .busy_addr(busy_addr),
        .rd_busy(rd_busy_b));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            mem_a[i] = 8'(i + 1);
            mem_b[i] = (i == 0) ? 8'h00 : 8'(i + 1);
            bsy_a[i] = 1'b0;
            bsy_b[i] = 1'b0;
        end
    endtask

    task automatic model_update();
        if (clr) begin
            model_reset();
        end else begin
            if (we) begin
                mem_a[waddr] = wdata;
                bsy_a[waddr] = 1'b0;
                if (waddr != 0) begin
                    mem_b[waddr] = wdata;
                    bsy_b[waddr] = 1'b0;
                end
            end
            if (busy_set) begin
                bsy_a[busy_addr] = 1'b1;
                if (busy_addr != 0) bsy_b[busy_addr] = 1'b1;
            end
        end
    endtask

    // One clock: config A checked combinationally before the edge, config B
    // checked just after it against what its ports saw before the edge.
    task automatic run_cycle(input string tag);
        logic [7:0] ed;
        logic       eb;
        @(negedge clk);
        for (int p = 0; p < 2; p++) begin
            if (we && !clr && waddr == ra[p]) begin
                ed = wdata;
                eb = busy_set && (busy_addr == ra[p]);
            end else begin
                ed = mem_a[ra[p]];
                eb = bsy_a[ra[p]];
            end
            check($sformatf("%s A.rdata%0d", tag, p), 32'(rdata_a[p*8 +: 8]), 32'(ed));
            check($sformatf("%s A.busy%0d", tag, p), 32'(rd_busy_a[p]), 32'(eb));
            pend_d[p] = mem_b[ra[p]];
            pend_b[p] = bsy_b[ra[p]];
        end
        @(posedge clk);
        model_update();
        #1;
        for (int p = 0; p < 2; p++) begin
            check($sformatf("%s B.rdata%0d", tag, p), 32'(rdata_b[p*8 +: 8]), 32'(pend_d[p]));
            check($sformatf("%s B.busy%0d", tag, p), 32'(rd_busy_b[p]), 32'(pend_b[p]));
        end
        $display("cyc %-8s clr=%0b we=%0b wa=%0d wd=%02h set=%0b ba=%0d ra=%0d/%0d A=%04h/%02b B=%04h/%02b",
                 tag, clr, we, waddr, wdata, busy_set, busy_addr, ra[0], ra[1],
                 rdata_a, rd_busy_a, rdata_b, rd_busy_b);
    endtask

    task automatic drive(input logic c, input logic w, input logic [2:0] wa, input logic [7:0] wd,
                         input logic s, input logic [2:0] sa, input logic [2:0] r0, input logic [2:0] r1);
        clr = c; we = w; waddr = wa; wdata = wd; busy_set = s; busy_addr = sa;
        ra[0] = r0; ra[1] = r1;
    endtask

    initial begin
        ra[0] = '0; ra[1] = '0;
        model_reset();
        #12;
        check("rst B.rdata", 32'(rdata_b), 32'h0);
        check("rst B.busy", 32'(rd_busy_b), 32'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Dirty some state, then reset in the middle of a write.
        drive(0, 1, 3'd4, 8'h99, 1, 3'd6, 3'd0, 3'd0); run_cycle("pre");
        drive(0, 1, 3'd2, 8'hEE, 0, 3'd0, 3'd2, 3'd6);
        #3 rst_n = 1'b0;
        model_reset();
        @(posedge clk); #1;
        we = 1'b0;
        for (int i = 0; i < 8; i += 2) begin
            ra[0] = 3'(i); ra[1] = 3'(i + 1); #1;
            check($sformatf("rst A.rdata r%0d", i), 32'(rdata_a), {16'h0, 8'(i + 2), 8'(i + 1)});
            check("rst A.busy", 32'(rd_busy_a), 32'h0);
            check("rst B.rdata", 32'(rdata_b), 32'h0);
        end
        #2 rst_n = 1'b1;
        @(posedge clk); #1;

        // Write then read back.
        drive(0, 1, 3'd3, 8'hA5, 0, 3'd0, 3'd0, 3'd1); run_cycle("wr");
        drive(0, 0, 3'd0, 8'h00, 0, 3'd0, 3'd3, 3'd3); run_cycle("rd");
        drive(0, 0, 3'd0, 8'h00, 0, 3'd0, 3'd3, 3'd0); run_cycle("rd2");
        check("rd B.rdata0 A5", 32'(rdata_b[7:0]), 32'hA5);

        // Bypass on both ports.
        drive(0, 1, 3'd5, 8'h3C, 0, 3'd0, 3'd5, 3'd5);
        #1 check("byp A both 3C", 32'(rdata_a), 32'h3C3C);
        run_cycle("byp");
        check("byp B pre-write 06", 32'(rdata_b), 32'h0606);
        drive(0, 0, 3'd0, 8'h00, 0, 3'd0, 3'd5, 3'd5); run_cycle("byp2");
        check("byp B next 3C", 32'(rdata_b), 32'h3C3C);

        // Scoreboard: set, clear by write, set+write together.
        drive(0, 0, 3'd0, 8'h00, 1, 3'd2, 3'd2, 3'd1); run_cycle("set");
        drive(0, 0, 3'd0, 8'h00, 0, 3'd0, 3'd2, 3'd1); run_cycle("busy");
        drive(0, 1, 3'd2, 8'h11, 0, 3'd0, 3'd2, 3'd2); run_cycle("wclr");
        drive(0, 1, 3'd2, 8'h22, 1, 3'd2, 3'd2, 3'd0); run_cycle("setwr");
        drive(0, 0, 3'd0, 8'h00, 0, 3'd0, 3'd2, 3'd2); run_cycle("still");
        check("setwr A.busy", 32'(rd_busy_a), 32'h3);

        // Zero register drop on config B.
        drive(0, 1, 3'd0, 8'hFF, 1, 3'd0, 3'd0, 3'd0); run_cycle("zero");
        drive(0, 0, 3'd0, 8'h00, 0, 3'd0, 3'd0, 3'd0); run_cycle("zero2");
        check("zero B.rdata", 32'(rdata_b), 32'h0);
        check("zero B.busy", 32'(rd_busy_b), 32'h0);

        // clr beats a concurrent write and busy mark.
        drive(0, 0, 3'd0, 8'h00, 1, 3'd3, 3'd1, 3'd3); run_cycle("pend");
        drive(0, 1, 3'd1, 8'h77, 1, 3'd1, 3'd1, 3'd3); clr = 1'b1; run_cycle("clr");
        drive(0, 0, 3'd0, 8'h00, 0, 3'd0, 3'd1, 3'd3); run_cycle("clr2");
        check("clr A.rdata0 02", 32'(rdata_a[7:0]), 32'h02);
        check("clr A.busy", 32'(rd_busy_a), 32'h0);

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            drive(($urandom_range(31) == 0), 1'($urandom), 3'($urandom), 8'($urandom),
                  1'($urandom), 3'($urandom), 3'($urandom), 3'($urandom));
            if ($urandom_range(3) == 0) ra[1] = ra[0];
            if ($urandom_range(3) == 0) waddr = ra[$urandom_range(1)];
            run_cycle("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
